// File: rtl/ebike_pkg.sv
//----------------------------------------------------------------------------
// ebike_pkg
// Shared constants, types and helpers for the e-bike pedal-sensor path.
// CADENCE_MAX     : largest reportable cadence (5-bit saturation point)
// NOT_PED_THRESH  : cadence below this value means the rider is not pedaling
// AVG_SH_DEFAULT  : default exponential-average shift (new-sample weight 1/16)
// torque_t        : 12-bit unsigned ADC torque sample
// cadence_t       : 5-bit pulses-per-window count
//----------------------------------------------------------------------------
`timescale 1ns/1ps
package ebike_pkg;

    localparam logic [4:0] CADENCE_MAX    = 5'd31;
    localparam logic [4:0] NOT_PED_THRESH = 5'd2;
    localparam int         AVG_SH_DEFAULT = 4;

    typedef logic [11:0] torque_t;
    typedef logic [4:0]  cadence_t;

    // Adds one pulse to a count, holding at CADENCE_MAX instead of wrapping.
    function automatic cadence_t satInc(input cadence_t count, input logic inc);
        satInc = (inc && (count != CADENCE_MAX)) ? count + 5'd1 : count;
    endfunction

endpackage

// File: rtl/cadence_sync.sv
//----------------------------------------------------------------------------
// cadence_sync
// Brings the asynchronous pedal-magnet pulse into the clk domain and turns
// each rising edge into a single-cycle pulse.
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   i_cadenceRaw : raw pedal-magnet pulse, asynchronous to clk
//   o_rise       : high for exactly one cycle per synchronized rising edge
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module cadence_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_cadenceRaw,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Two metastability flops, then a third holding the previous synchronized
    // level so a rising edge can be spotted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_cadenceRaw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/sensor_cond.sv
//----------------------------------------------------------------------------
// sensor_cond
// Conditions raw pedal sensors for the assist-current computation: counts
// cadence pulses per fixed window and keeps an exponential average of crank
// torque updated once per pedal pulse.
// Parameters:
//   WIN_W  : cadence window is 2^WIN_W clk cycles
//   AVG_SH : average shift; a new torque sample has weight 1/2^AVG_SH
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   torque       : unsigned crank torque, already synchronous to clk
//   cadence_raw  : raw pedal-magnet pulse, asynchronous to clk
//   avg_torque   : filtered torque
//   cadence      : pulses in the last completed window, saturating at 31
//   not_pedaling : high while cadence < 2
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module sensor_cond
    import ebike_pkg::*;
#(
    parameter int WIN_W  = 22,
    parameter int AVG_SH = AVG_SH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] torque,
    input  logic        cadence_raw,
    output logic [11:0] avg_torque,
    output logic [4:0]  cadence,
    output logic        not_pedaling
);

    // The accumulator holds 2^AVG_SH times the average, so it needs AVG_SH
    // extra bits above the 12-bit torque.
    localparam int ACC_W = 12 + AVG_SH;

    logic             w_rise;
    logic             w_terminal;
    cadence_t         w_countNext;
    logic [ACC_W-1:0] w_accNext;

    logic [WIN_W-1:0] r_winCount;
    cadence_t         r_pulseCount;
    cadence_t         r_cadence;
    logic             r_notPedaling;
    logic [ACC_W-1:0] r_acc;

    cadence_sync u_cadenceSync (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cadenceRaw (cadence_raw),
        .o_rise       (w_rise)
    );

    assign w_terminal  = &r_winCount;
    assign w_countNext = satInc(r_pulseCount, w_rise);

    // Free-running window timer; the all-ones cycle closes the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winCount <= '0;
        end else begin
            r_winCount <= r_winCount + 1'b1;
        end
    end

    // Pulse counting. A rise in the terminal cycle belongs to the window that
    // is closing, so the published cadence uses the already-incremented count
    // and the counter restarts from zero rather than from that pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulseCount  <= '0;
            r_cadence     <= '0;
            r_notPedaling <= 1'b1;
        end else if (w_terminal) begin
            r_pulseCount  <= '0;
            r_cadence     <= w_countNext;
            r_notPedaling <= (w_countNext < NOT_PED_THRESH);
        end else begin
            r_pulseCount  <= w_countNext;
        end
    end

    // Torque average, touched only on a pedal pulse. When the rider was not
    // pedaling the stale average is discarded and reseeded from the current
    // sample; otherwise a standard 1/2^AVG_SH exponential step is applied.
    // The step cannot exceed the accumulator range, so no saturation exists.
    always_comb begin
        w_accNext = r_acc;
        if (w_rise) begin
            if (r_notPedaling) begin
                w_accNext = {torque, {AVG_SH{1'b0}}};
            end else begin
                w_accNext = r_acc - (r_acc >> AVG_SH) + {{AVG_SH{1'b0}}, torque};
            end
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_accNext;
        end
    end

    assign avg_torque   = r_acc[ACC_W-1:AVG_SH];
    assign cadence      = r_cadence;
    assign not_pedaling = r_notPedaling;

endmodule

// File: tb/tb_sensor_cond.sv
//----------------------------------------------------------------------------
// tb_sensor_cond
// Self-checking bench for sensor_cond with a 1024-cycle cadence window.
// A reference model predicts the average after every pedal pulse and the
// cadence/not_pedaling result at every window end; predictions are queued
// when a pulse is driven and checked by a monitor once that edge has passed.
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sensor_cond;

    localparam int WIN_W   = 10;
    localparam int WIN_LEN = 1 << WIN_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] torque = 12'h000;
    logic        cadence_raw = 1'b0;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;

    int errors = 0;
    int checks = 0;
    int edgeCount;

    typedef struct {
        int         edgeNo;
        bit         isWindow;
        logic [11:0] avg;
        logic [4:0]  cad;
        logic        np;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monEntry;
    logic [15:0] mAcc = 16'h0000;
    int          mCount = 0;
    logic [4:0]  mCad = 5'd0;
    logic        mNotPed = 1'b1;
    int          mWinEnd = WIN_LEN;

    sensor_cond #(
        .WIN_W  (WIN_W),
        .AVG_SH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .torque       (torque),
        .cadence_raw  (cadence_raw),
        .avg_torque   (avg_torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Number of clk edges since reset release; window m ends on edge 1024*(m+1).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edgeCount <= 0;
        else        edgeCount <= edgeCount + 1;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        mAcc    = 16'h0000;
        mCount  = 0;
        mCad    = 5'd0;
        mNotPed = 1'b1;
        mWinEnd = WIN_LEN;
        expQ.delete();
    endtask

    // Publishes model window results for every window ending at or before upto.
    task automatic closeWindows(input int upto);
        exp_t e;
        while (mWinEnd <= upto) begin
            mCad        = 5'(mCount);
            mNotPed     = (mCount < 2);
            e.edgeNo    = mWinEnd;
            e.isWindow  = 1'b1;
            e.avg       = 12'h000;
            e.cad       = mCad;
            e.np        = mNotPed;
            expQ.push_back(e);
            mCount      = 0;
            mWinEnd     = mWinEnd + WIN_LEN;
        end
    endtask

    // Monitor: after each clk edge, compare every prediction due by now.
    always @(negedge clk) begin
        if (rst_n) begin
            closeWindows(edgeCount);
            while (expQ.size() > 0 && expQ[0].edgeNo <= edgeCount) begin
                monEntry = expQ.pop_front();
                if (monEntry.isWindow) begin
                    checks++;
                    if (cadence !== monEntry.cad) begin
                        errors++;
                        $display("[TB] FAIL window_cadence edge %0d: got %h, expected %h", monEntry.edgeNo, cadence, monEntry.cad);
                    end
                    checks++;
                    if (not_pedaling !== monEntry.np) begin
                        errors++;
                        $display("[TB] FAIL window_not_pedaling edge %0d: got %b, expected %b", monEntry.edgeNo, not_pedaling, monEntry.np);
                    end
                end else begin
                    checks++;
                    if (avg_torque !== monEntry.avg) begin
                        errors++;
                        $display("[TB] FAIL pulse_avg edge %0d: got %h, expected %h", monEntry.edgeNo, avg_torque, monEntry.avg);
                    end
                end
            end
        end
    end

    // All stimulus is applied 2 ns after a rising clk edge.
    task automatic stepEdge();
        @(posedge clk);
        #2;
    endtask

    task automatic alignWindow(input int offset);
        while ((edgeCount % WIN_LEN) != offset) stepEdge();
    endtask

    // Raises cadence_raw and queues the predicted average for the edge at
    // which the synchronized rise is consumed (two edges after the next one).
    task automatic startPulse(output int eEdge);
        exp_t e;
        cadence_raw = 1'b1;
        eEdge = edgeCount + 3;
        closeWindows(eEdge - 1);
        if (mNotPed) mAcc = {torque, 4'h0};
        else         mAcc = mAcc - (mAcc >> 4) + {4'h0, torque};
        if (mCount < 31) mCount++;
        e.edgeNo   = eEdge;
        e.isWindow = 1'b0;
        e.avg      = mAcc[15:4];
        e.cad      = 5'd0;
        e.np       = 1'b0;
        expQ.push_back(e);
    endtask

    task automatic pulse();
        int e;
        startPulse(e);
        stepEdge();
        stepEdge();
        cadence_raw = 1'b0;
        stepEdge();
        stepEdge();
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n = 1'b0;
        torque = 12'hFFF;
        for (int i = 0; i < 6; i++) begin
            cadence_raw = ~cadence_raw;
            #7;
            checks++;
            if (avg_torque !== 12'h000) begin errors++; $display("[TB] FAIL reset_avg: got %h, expected 000", avg_torque); end
            checks++;
            if (cadence !== 5'h00) begin errors++; $display("[TB] FAIL reset_cadence: got %h, expected 00", cadence); end
            checks++;
            if (not_pedaling !== 1'b1) begin errors++; $display("[TB] FAIL reset_not_pedaling: got %b, expected 1", not_pedaling); end
        end
        cadence_raw = 1'b0;
        @(posedge clk);
        #2;
        modelReset();
        rst_n = 1'b1;
        repeat (10) stepEdge();
        checks++;
        if (avg_torque !== 12'h000 || cadence !== 5'h00 || not_pedaling !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_release: got avg=%h cad=%h np=%b, expected 000/00/1", avg_torque, cadence, not_pedaling);
        end
        alignWindow(WIN_LEN - 1);
        checks++;
        if (avg_torque !== 12'h000 || cadence !== 5'h00 || not_pedaling !== 1'b1) begin
            errors++;
            $display("[TB] FAIL before_first_window_end: got avg=%h cad=%h np=%b, expected 000/00/1", avg_torque, cadence, not_pedaling);
        end
        alignWindow(1);
    endtask

    task automatic test_steady();
        $display("[TB] test_steady");
        torque = 12'h800;
        alignWindow(1);
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 16; k++) begin
                pulse();
                repeat (60) stepEdge();
            end
            checks++;
            if (cadence !== 5'h10) begin errors++; $display("[TB] FAIL steady_cadence w%0d: got %h, expected 10", w, cadence); end
            checks++;
            if (not_pedaling !== 1'b0) begin errors++; $display("[TB] FAIL steady_not_pedaling w%0d: got %b, expected 0", w, not_pedaling); end
            checks++;
            if (avg_torque !== 12'h800) begin errors++; $display("[TB] FAIL steady_avg w%0d: got %h, expected 800", w, avg_torque); end
        end
    endtask

    task automatic test_step();
        int e;
        logic [11:0] oldExp;
        logic [11:0] newExp;
        $display("[TB] test_step");
        torque = 12'h000;
        oldExp = 12'h800;
        newExp = 12'h780;
        for (int i = 0; i < 2; i++) begin
            startPulse(e);
            stepEdge();
            stepEdge();
            cadence_raw = 1'b0;
            checks++;
            if (avg_torque !== oldExp) begin errors++; $display("[TB] FAIL step_before_latency p%0d: got %h, expected %h", i, avg_torque, oldExp); end
            stepEdge();
            checks++;
            if (avg_torque !== newExp) begin errors++; $display("[TB] FAIL step_after_latency p%0d: got %h, expected %h", i, avg_torque, newExp); end
            stepEdge();
            stepEdge();
            oldExp = 12'h780;
            newExp = 12'h708;
        end
    endtask

    task automatic test_saturate();
        $display("[TB] test_saturate");
        torque = 12'h800;
        alignWindow(1);
        for (int k = 0; k < 40; k++) pulse();
        alignWindow(1);
        checks++;
        if (cadence !== 5'h1F) begin errors++; $display("[TB] FAIL saturate_cadence: got %h, expected 1F", cadence); end
        checks++;
        if (not_pedaling !== 1'b0) begin errors++; $display("[TB] FAIL saturate_not_pedaling: got %b, expected 0", not_pedaling); end
        pulse();
        alignWindow(1);
        checks++;
        if (cadence !== 5'h01) begin errors++; $display("[TB] FAIL single_cadence: got %h, expected 01", cadence); end
        checks++;
        if (not_pedaling !== 1'b1) begin errors++; $display("[TB] FAIL single_not_pedaling: got %b, expected 1", not_pedaling); end
        torque = 12'h3A0;
        pulse();
        checks++;
        if (avg_torque !== 12'h3A0) begin errors++; $display("[TB] FAIL reseed_avg: got %h, expected 3A0", avg_torque); end
    endtask

    task automatic test_terminal();
        $display("[TB] test_terminal");
        torque = 12'h600;
        alignWindow(1);
        for (int k = 0; k < 4; k++) pulse();
        alignWindow(WIN_LEN - 3);
        pulse();
        checks++;
        if (cadence !== 5'h05) begin errors++; $display("[TB] FAIL terminal_cadence: got %h, expected 05", cadence); end
        pulse();
        pulse();
        alignWindow(1);
        checks++;
        if (cadence !== 5'h02) begin errors++; $display("[TB] FAIL after_terminal_cadence: got %h, expected 02", cadence); end
        checks++;
        if (not_pedaling !== 1'b0) begin errors++; $display("[TB] FAIL after_terminal_not_pedaling: got %b, expected 0", not_pedaling); end
    endtask

    task automatic test_midreset();
        $display("[TB] test_midreset");
        stepEdge();
        alignWindow(1);
        checks++;
        if (not_pedaling !== 1'b1) begin errors++; $display("[TB] FAIL idle_not_pedaling: got %b, expected 1", not_pedaling); end
        torque = 12'h800;
        pulse();
        pulse();
        checks++;
        if (avg_torque !== 12'h800) begin errors++; $display("[TB] FAIL preset_avg: got %h, expected 800", avg_torque); end
        repeat (20) stepEdge();
        rst_n = 1'b0;
        modelReset();
        #1;
        checks++;
        if (avg_torque !== 12'h000 || cadence !== 5'h00 || not_pedaling !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset: got avg=%h cad=%h np=%b, expected 000/00/1", avg_torque, cadence, not_pedaling);
        end
        stepEdge();
        stepEdge();
        rst_n = 1'b1;
        torque = 12'h500;
        alignWindow(1);
        for (int k = 0; k < 3; k++) pulse();
        checks++;
        if (avg_torque !== 12'h500) begin errors++; $display("[TB] FAIL postreset_seed_avg: got %h, expected 500", avg_torque); end
        alignWindow(1);
        checks++;
        if (cadence !== 5'h03) begin errors++; $display("[TB] FAIL postreset_cadence: got %h, expected 03", cadence); end
        checks++;
        if (not_pedaling !== 1'b0) begin errors++; $display("[TB] FAIL postreset_not_pedaling: got %b, expected 0", not_pedaling); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_step();
        test_saturate();
        test_terminal();
        test_midreset();
        repeat (4) stepEdge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
